// File: rtl/ddr_rd_pkg.sv
// rtl/ddr_rd_pkg.sv - shared FSM encoding and frame geometry helpers for ddr_rd_ctrl
package ddr_rd_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WAIT, ST_DONE} rd_state_t;

   function automatic int half_beats(input int h_width, input int dq_width);
      return (h_width / 2) * 16 / (dq_width * 8);
   endfunction

   function automatic int bursts_per_half(input int h_width, input int dq_width, input int burst_len);
      return half_beats(h_width, dq_width) / burst_len;
   endfunction

   function automatic int line_words(input int h_width, input int dq_width);
      return (h_width / 2) * 16 / dq_width;
   endfunction

   function automatic int ch_frame_words(input int h_width, input int h_height, input int dq_width);
      return line_words(h_width, dq_width) * (h_height / 2);
   endfunction

   // Values for the default 32-bit DDR, 1280x720 RGB565, 8-beat configuration
   localparam int HALF_BEATS      = half_beats(1280, 32);
   localparam int BURSTS_PER_HALF = bursts_per_half(1280, 32, 8);
   localparam int LINE_WORDS      = line_words(1280, 32);
   localparam int CH_FRAME_WORDS  = ch_frame_words(1280, 720, 32);

endpackage

// File: rtl/ddr_rd_addr_gen.sv
// rtl/ddr_rd_addr_gen.sv - maps read bank, display row, half and burst index to a DDR word address
module ddr_rd_addr_gen
   import ddr_rd_pkg::*;
#(
   parameter int DQ_WIDTH   = 32,
   parameter int H_WIDTH    = 1280,
   parameter int H_HEIGHT   = 720,
   parameter int BURST_LEN  = 8,
   parameter int ADDR_WIDTH = 28,
   parameter int ROW_W      = 10
)(
   input  logic                  bank,
   input  logic [ROW_W-1:0]      row,
   input  logic                  half,
   input  logic [7:0]            burst_idx,
   output logic [ADDR_WIDTH-1:0] addr
);

   localparam int LW          = line_words(H_WIDTH, DQ_WIDTH);
   localparam int CFW         = ch_frame_words(H_WIDTH, H_HEIGHT, DQ_WIDTH);
   localparam int BURST_WORDS = BURST_LEN * (DQ_WIDTH * 8 / DQ_WIDTH);
   localparam int HALF_ROWS   = H_HEIGHT / 2;

   logic             lower;
   logic [2:0]       ch;
   logic [ROW_W-1:0] src_line;

   // Lower display half is fed by channels 2/3; bank selects the upper group of four
   always_comb begin
      lower    = (row >= ROW_W'(HALF_ROWS));
      ch       = {bank, lower, half};
      src_line = lower ? row - ROW_W'(HALF_ROWS) : row;
   end

   assign addr = ADDR_WIDTH'(ch) * ADDR_WIDTH'(CFW)
               + ADDR_WIDTH'(src_line) * ADDR_WIDTH'(LW)
               + ADDR_WIDTH'(burst_idx) * ADDR_WIDTH'(BURST_WORDS);

endmodule

// File: rtl/ddr_rd_ctrl.sv
// rtl/ddr_rd_ctrl.sv - fetches one display line per request from the read bank, left half then right half
// DDR_RD_CTRL_PREFETCH_EN: vsync_in starts the row 0 fetch without waiting for line_req
module ddr_rd_ctrl
   import ddr_rd_pkg::*;
#(
   parameter int DQ_WIDTH   = 32,
   parameter int H_WIDTH    = 1280,
   parameter int H_HEIGHT   = 720,
   parameter int BURST_LEN  = 8,
   parameter int ADDR_WIDTH = 28
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vsync_in,
   input  logic                  line_req,
   input  logic                  wr_bank,
   output logic                  rd_cmd_valid,
   input  logic                  rd_cmd_ready,
   output logic [ADDR_WIDTH-1:0] rd_cmd_addr,
   output logic [7:0]            rd_cmd_len,
   input  logic                  rd_data_valid,
   input  logic                  rd_data_last,
   output logic                  buf_wr_en,
   output logic                  line_done,
   output logic                  busy,
   output logic                  err_overrun
);

   localparam int BPH   = bursts_per_half(H_WIDTH, DQ_WIDTH, BURST_LEN);
   localparam int ROW_W = $clog2(H_HEIGHT);
`ifdef DDR_RD_CTRL_PREFETCH_EN
   localparam bit PREFETCH = 1'b1;
`else
   localparam bit PREFETCH = 1'b0;
`endif

   rd_state_t        state;
   logic [ROW_W-1:0] row;
   logic [ROW_W-1:0] cur_row;
   logic [7:0]       burst_idx;
   logic             half;
   logic             rd_bank;
   logic             pending;
   logic             discard;
   logic             beat_end;
   logic             last_burst;

   assign beat_end   = rd_data_valid & rd_data_last;
   assign last_burst = half & (burst_idx == 8'(BPH - 1));
   assign busy       = (state != ST_IDLE);
   assign buf_wr_en  = (state == ST_WAIT) & rd_data_valid & ~discard & ~vsync_in;

   // Address comes from the per-line snapshot so a vsync cannot move a held command
   ddr_rd_addr_gen #(
      .DQ_WIDTH(DQ_WIDTH), .H_WIDTH(H_WIDTH), .H_HEIGHT(H_HEIGHT),
      .BURST_LEN(BURST_LEN), .ADDR_WIDTH(ADDR_WIDTH), .ROW_W(ROW_W)
   ) u_addr_gen (
      .bank(rd_bank), .row(cur_row), .half(half), .burst_idx(burst_idx), .addr(rd_cmd_addr)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         row          <= '0;
         cur_row      <= '0;
         burst_idx    <= '0;
         half         <= 1'b0;
         rd_bank      <= 1'b0;
         pending      <= 1'b0;
         discard      <= 1'b0;
         rd_cmd_valid <= 1'b0;
         rd_cmd_len   <= '0;
         line_done    <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         line_done <= 1'b0;

         if (vsync_in) begin
            row         <= '0;
            pending     <= PREFETCH;
            err_overrun <= 1'b0;
            if (state == ST_CMD || state == ST_WAIT)
               discard <= 1'b1;
         end else if (state == ST_IDLE) begin
            pending <= pending & line_req;
         end else if (line_req) begin
            if (pending)
               err_overrun <= 1'b1;
            pending <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (!vsync_in && (line_req || pending)) begin
                  state        <= ST_CMD;
                  rd_bank      <= ~wr_bank;
                  cur_row      <= row;
                  half         <= 1'b0;
                  burst_idx    <= '0;
                  rd_cmd_valid <= 1'b1;
                  rd_cmd_len   <= 8'(BURST_LEN - 1);
               end
            end
            ST_CMD: begin
               if (rd_cmd_ready) begin
                  rd_cmd_valid <= 1'b0;
                  state        <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (beat_end) begin
                  if (discard || vsync_in) begin
                     discard <= 1'b0;
                     state   <= ST_IDLE;
                  end else if (last_burst) begin
                     line_done <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     rd_cmd_valid <= 1'b1;
                     state        <= ST_CMD;
                     if (burst_idx == 8'(BPH - 1)) begin
                        half      <= 1'b1;
                        burst_idx <= '0;
                     end else begin
                        burst_idx <= burst_idx + 8'd1;
                     end
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               if (!vsync_in)
                  row <= (row == ROW_W'(H_HEIGHT - 1)) ? '0 : row + 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_rd_ctrl.sv
// tb/tb_ddr_rd_ctrl.sv - directed self-checking bench for ddr_rd_ctrl with a simple DDR read responder
module tb_ddr_rd_ctrl;

   localparam int AW  = 28;
   localparam int CFW = 115200;
   localparam int LW  = 320;

   logic          clk = 1'b0;
   logic          rst, vsync_in, line_req, wr_bank, rd_cmd_ready;
   logic          rd_cmd_valid, rd_data_valid, rd_data_last;
   logic          buf_wr_en, line_done, busy, err_overrun;
   logic [AW-1:0] rd_cmd_addr;
   logic [7:0]    rd_cmd_len;

   int   checks = 0, failures = 0;
   int   cyc = 0, cmd_cnt = 0, wr_cnt = 0, done_cnt = 0;
   int   addr_q[$];
   int   hs_cyc[$];
   int   done_cyc[$];
   int   beats_per_burst = 8;
   int   beats_left = 0;
   logic nv = 1'b0, nl = 1'b0, dv_q = 1'b0, dl_q = 1'b0, stray = 1'b0;
   logic [7:0] last_len = 8'd0;

   ddr_rd_ctrl dut (
      .clk(clk), .rst(rst), .vsync_in(vsync_in), .line_req(line_req), .wr_bank(wr_bank),
      .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
      .rd_cmd_len(rd_cmd_len), .rd_data_valid(rd_data_valid), .rd_data_last(rd_data_last),
      .buf_wr_en(buf_wr_en), .line_done(line_done), .busy(busy), .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign rd_data_valid = dv_q | stray;
   assign rd_data_last  = dl_q;

   // Monitor and DDR responder: beats start the cycle after the accepted command
   always @(negedge clk) begin
      if (rd_cmd_valid && rd_cmd_ready) begin
         cmd_cnt++;
         addr_q.push_back(int'(rd_cmd_addr));
         hs_cyc.push_back(cyc);
         last_len   = rd_cmd_len;
         beats_left = beats_per_burst;
      end
      if (buf_wr_en) wr_cnt++;
      if (line_done) begin
         done_cnt++;
         done_cyc.push_back(cyc);
      end
      if (beats_left > 0) begin
         nv = 1'b1;
         nl = (beats_left == 1);
         beats_left--;
      end else begin
         nv = 1'b0;
         nl = 1'b0;
      end
   end

   always @(posedge clk) begin
      #1;
      dv_q = nv;
      dl_q = nl;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_req();
      line_req = 1'b1;
      tick();
      line_req = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (!ok && n < budget) begin
         @(negedge clk);
         if (line_done) ok = 1'b1;
         n++;
      end
      if (!ok) check(tag, 64'd0, 64'd1);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", busy, 1'b0);
      tick();
   endtask

   task automatic fetch_line(input int budget, input string tag, output bit ok);
      pulse_req();
      wait_done(budget, tag, ok);
      tick();
      wait_idle(60);
   endtask

   initial begin
      int b_cmd, b_wr, b_done, hs, n, fast_ok;
      bit ok;

      rst = 1'b1; vsync_in = 1'b0; line_req = 1'b0; wr_bank = 1'b1; rd_cmd_ready = 1'b1;
      #3 rst = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_cmd_valid", rd_cmd_valid, 1'b0);
      check("rst_cmd_addr", rd_cmd_addr, 0);
      check("rst_cmd_len", rd_cmd_len, 0);
      check("rst_buf_wr_en", buf_wr_en, 1'b0);
      check("rst_line_done", line_done, 1'b0);
      check("rst_err_overrun", err_overrun, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      tick();

      // Stray data in IDLE must not reach the line buffer
      stray = 1'b1;
      @(negedge clk);
      check("idle_stray_wr_en", buf_wr_en, 1'b0);
      check("idle_stray_busy", busy, 1'b0);
      tick();
      stray = 1'b0;

      // Row 0, wr_bank=1; flipping wr_bank mid-line must not move the addresses
      b_cmd = cmd_cnt; b_wr = wr_cnt; b_done = done_cnt;
      pulse_req();
      tick();
      wr_bank = 1'b0;
      wait_done(300, "row0_timeout", ok);
      tick();
      wait_idle(60);
      check("row0_cmds", cmd_cnt - b_cmd, 10);
      for (int i = 0; i < 10; i++)
         check($sformatf("row0_addr%0d", i), addr_q[b_cmd + i],
               (i < 5) ? i * 64 : CFW + (i - 5) * 64);
      check("row0_beats", wr_cnt - b_wr, 80);
      check("row0_done", done_cnt - b_done, 1);
      check("row0_len", last_len, 8'd7);

      // Row 1 with the command held off for 10 cycles
      wr_bank = 1'b1; rd_cmd_ready = 1'b0;
      b_cmd = cmd_cnt; b_done = done_cnt;
      pulse_req();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("hold_cyc%0d", i), {rd_cmd_valid, rd_cmd_addr}, {1'b1, 28'd320});
      end
      tick();
      rd_cmd_ready = 1'b1;
      wait_done(300, "row1_timeout", ok);
      tick();
      wait_idle(60);
      check("row1_cmds", cmd_cnt - b_cmd, 10);
      check("row1_addr0", addr_q[b_cmd], LW);
      check("row1_addr5", addr_q[b_cmd + 5], CFW + LW);

      // Rows 2 and 3: one pending request, the third request overruns
      b_cmd = cmd_cnt; b_done = done_cnt;
      pulse_req();
      repeat (4) tick();
      pulse_req();
      @(negedge clk);
      check("pend_no_err", err_overrun, 1'b0);
      tick();
      repeat (4) tick();
      pulse_req();
      @(negedge clk);
      check("overrun_err", err_overrun, 1'b1);
      tick();
      wait_done(300, "row2_timeout", ok);
      wait_done(300, "row3_timeout", ok);
      tick();
      wait_idle(60);
      check("pend_cmds", cmd_cnt - b_cmd, 20);
      check("pend_row3_addr", addr_q[b_cmd + 10], 3 * LW);
      check("pend_gap", hs_cyc[b_cmd + 10] - done_cyc[b_done], 2);
      check("overrun_sticky", err_overrun, 1'b1);

      // Row 4 aborted by vsync during the third burst
      b_cmd = cmd_cnt; b_wr = wr_cnt; b_done = done_cnt;
      pulse_req();
      hs = 0; n = 0;
      while (hs < 3 && n < 200) begin
         @(negedge clk);
         if (rd_cmd_valid && rd_cmd_ready) hs++;
         n++;
      end
      if (hs < 3) check("vs_wait_timeout", hs, 3);
      repeat (3) @(posedge clk);
      #1 vsync_in = 1'b1;
      tick();
      vsync_in = 1'b0;
      wait_idle(60);
      repeat (3) tick();
      check("vs_beats", wr_cnt - b_wr, 18);
      check("vs_cmds", cmd_cnt - b_cmd, 3);
      check("vs_no_done", done_cnt - b_done, 0);
      check("vs_err_clr", err_overrun, 1'b0);
      check("vs_idle", busy, 1'b0);

      wr_bank = 1'b0;
      b_cmd = cmd_cnt; b_wr = wr_cnt;
      fetch_line(300, "vs_row0_timeout", ok);
      check("vs_row0_addr", addr_q[b_cmd], 4 * CFW);
      check("vs_row0_beats", wr_cnt - b_wr, 80);

      // Skip quickly to row 360 using one-beat bursts
      beats_per_burst = 1;
      fast_ok = 0;
      for (int i = 0; i < 359; i++) begin
         fetch_line(100, "fast1_timeout", ok);
         if (ok) fast_ok++;
      end
      check("fast1_lines", fast_ok, 359);
      beats_per_burst = 8;
      b_cmd = cmd_cnt; b_wr = wr_cnt;
      fetch_line(300, "row360_timeout", ok);
      check("row360_left", addr_q[b_cmd], 691200);
      check("row360_right", addr_q[b_cmd + 5], 806400);
      check("row360_beats", wr_cnt - b_wr, 80);

      beats_per_burst = 1;
      fast_ok = 0;
      for (int i = 0; i < 358; i++) begin
         fetch_line(100, "fast2_timeout", ok);
         if (ok) fast_ok++;
      end
      check("fast2_lines", fast_ok, 358);
      b_cmd = cmd_cnt;
      fetch_line(100, "row719_timeout", ok);
      check("row719_first", addr_q[b_cmd], 806080);
      check("row719_last", addr_q[b_cmd + 9], 921536);
      b_cmd = cmd_cnt;
      fetch_line(100, "wrap_timeout", ok);
      check("wrap_row0", addr_q[b_cmd], 4 * CFW);

      // Row is now 1; vsync returns to row 0
      b_cmd = cmd_cnt;
      vsync_in = 1'b1;
      tick();
      vsync_in = 1'b0;
`ifdef DDR_RD_CTRL_PREFETCH_EN
      wait_done(100, "prefetch_timeout", ok);
      tick();
      wait_idle(60);
      check("prefetch_cmds", cmd_cnt - b_cmd, 10);
      check("prefetch_addr", addr_q[b_cmd], 4 * CFW);
`else
      hs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rd_cmd_valid) hs++;
      end
      check("no_auto_fetch", hs, 0);
      tick();
      fetch_line(100, "vsync_row0_timeout", ok);
      check("vsync_row0_addr", addr_q[b_cmd], 4 * CFW);
`endif

      // Asynchronous reset in the middle of a fetch
      pulse_req();
      repeat (3) tick();
      #2 rst = 1'b0;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_cmd_valid", rd_cmd_valid, 1'b0);
      check("arst_cmd_addr", rd_cmd_addr, 0);
      check("arst_buf_wr_en", buf_wr_en, 1'b0);
      tick();
      rst = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
